// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared widths, master-id type and read-tag type for the
//               two-master RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int unsigned c_addr_w_default = 10;
    localparam int unsigned c_data_w_default = 32;

    typedef logic master_id_t;

    // Outstanding read: which master gets the data returned next cycle
    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

    // m1 is treated as the previous winner so m0 takes the first contention
    localparam master_id_t c_last_grant_rst = 1'b1;

    function automatic master_id_t gnt_to_id(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant selection; purely combinational,
//               the last-grant pointer is held by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Under contention the master that did not win last time goes
            2'b11:   gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one single-port RAM between two Avalon-style masters
//               with round-robin arbitration and one-cycle read return.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int unsigned ADDR_W = c_addr_w_default,
    parameter  int unsigned DATA_W = c_data_w_default,
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_any_gnt;
    master_id_t        w_gnt_id;
    logic              w_sel_write;
    logic              w_gnt_write;
    logic              w_gnt_read;
    logic [BE_W-1:0]   w_sel_be;

    master_id_t        r_last_grant;
    rd_tag_t           r_rd_tag;

    // Requests are masked while reset is held so every grant-derived output
    // falls to its idle value immediately, without waiting for a clock.
    assign w_req = reset ? 2'b00
                         : {(m1_read | m1_write), (m0_read | m0_write)};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .gnt        (w_gnt)
    );

    assign w_any_gnt   = |w_gnt;
    assign w_gnt_id    = gnt_to_id(w_gnt);
    assign w_sel_write = (w_gnt_id == 1'b1) ? m1_write : m0_write;
    assign w_sel_be    = (w_gnt_id == 1'b1) ? m1_byteenable : m0_byteenable;

    // Read+write together is a write and must not produce a read return
    assign w_gnt_write = w_any_gnt & w_sel_write;
    assign w_gnt_read  = w_any_gnt & ~w_sel_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= c_last_grant_rst;
            r_rd_tag     <= '0;
        end else begin
            if (w_any_gnt) begin
                r_last_grant <= w_gnt_id;
            end
            r_rd_tag.valid <= w_gnt_read;
            r_rd_tag.id    <= w_gnt_id;
        end
    end

    assign m0_waitrequest   = ~w_gnt[0];
    assign m1_waitrequest   = ~w_gnt[1];

    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = r_rd_tag.valid & (r_rd_tag.id == 1'b0);
    assign m1_readdatavalid = r_rd_tag.valid & (r_rd_tag.id == 1'b1);

    assign ram_address      = (w_gnt_id == 1'b1) ? m1_address   : m0_address;
    assign ram_writedata    = (w_gnt_id == 1'b1) ? m1_writedata : m0_writedata;
    assign ram_byteenable   = w_gnt_write ? w_sel_be : {BE_W{1'b1}};
    assign ram_chipselect   = w_any_gnt;
    assign ram_write        = w_gnt_write;
    assign ram_clken        = ~reset;

endmodule
`default_nettype wire
